// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, single-outstanding imem
// requests, small instruction buffer toward decode, redirect/flush on retire jumps.
module fetch_unit #(
    parameter logic [31:0] START_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_in,
    input  logic [31:0]      new_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic [TAG_W-1:0] tag_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL  = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_ONE   = {{(TAG_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_req_pc;
    logic [TAG_W-1:0]   r_req_tag;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic [31:0]        r_fifo_instr [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [TAG_W-1:0]   r_fifo_tag   [FIFO_DEPTH];

    logic w_accept;
    logic w_push;
    logic w_pop;

    // A jump cycle never issues a request, so the old PC cannot leak to memory.
    assign imem_req  = !reset && (r_state == S_REQ) && (r_count < CNT_FULL) && !jump_in;
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;
    assign w_push    = (r_state == S_WAIT) && imem_rvalid && !jump_in;
    assign valid_out = (r_count != '0);
    assign w_pop     = valid_out && ready_in;

    assign instr_out = valid_out ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign pc_out    = valid_out ? r_fifo_pc[r_rd_ptr]    : 32'h0;
    assign tag_out   = valid_out ? r_fifo_tag[r_rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
            r_fifo_tag[r_wr_ptr]   <= r_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_REQ;
            r_pc      <= START_PC;
            r_tag     <= '0;
            r_req_pc  <= 32'h0;
            r_req_tag <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (jump_in) begin
                // Redirect wins over push/pop: the buffer is emptied outright.
                r_pc     <= new_pc & 32'hFFFF_FFFC;
                r_tag    <= r_tag + TAG_ONE;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end

            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state   <= S_WAIT;
                        r_req_pc  <= r_pc;
                        r_req_tag <= r_tag;
                    end
                end
                S_WAIT: begin
                    if (jump_in) begin
                        r_state <= imem_rvalid ? S_REQ : S_DROP;
                    end else if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    // The stale response must still be absorbed before refetching.
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
